xbar_slave_arbiter: RTL and testbench

XBAR_SLAVE_ARBITER -- requirements
Module: xbar_slave_arbiter

---
 rtl/xbar_pkg.sv | 17 +
 rtl/xbar_rr_arb.sv | 33 +++
 rtl/xbar_slave_arbiter.sv | 155 +++++++++++++++
 tb/tb_xbar_slave_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// xbar_pkg: shared constants and types for the crossbar slave-side arbiter.
//   CMD_READ / CMD_WRITE : encoding of the master command bit.
//   RESP_OK / RESP_ERR   : encoding of the completion status bit.
//   arb_state_e          : arbiter FSM states.
package xbar_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;
    localparam logic RESP_OK   = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    typedef enum logic {
        StIdle,
        StBusy
    } arb_state_e;

endpackage

// File: rtl/xbar_rr_arb.sv
// xbar_rr_arb: combinational round-robin pick.
//   eligible_i : one bit per master, set when that master may be granted.
//   ptr_i      : index where the upward search starts (wraps N-1 -> 0).
//   valid_o    : at least one eligible master.
//   grant_o    : first eligible index at or above ptr_i, wrapping.
module xbar_rr_arb #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    eligible_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IdxW-1:0] grant_o
);

    logic [IdxW-1:0] idx;

    // Scan from the farthest offset down to offset 0 so the closest hit to
    // ptr_i is the one that sticks. N is a power of 2, so index wrap is free.
    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr_i + IdxW'(k);
            if (eligible_i[idx]) begin
                valid_o = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// xbar_slave_arbiter: arbitrates N crossbar masters onto one slave port.
// Optional feature macro: XBAR_ARB_TIMEOUT_EN (error-completes a transaction
// after TIMEOUT busy cycles without slave ack).
//   clk_i, rst_ni            : clock, asynchronous active-low reset.
//   m_req_i/m_cmd_i          : per-master request and command (0 read, 1 write).
//   m_addr_i/m_wdata_i       : per-master address (top bits select slave), wdata.
//   m_ack_o                  : one-hot completion pulse to the granted master.
//   m_resp_o/m_rdata_o       : completion status and read data, valid with ack.
//   s_req_o/s_cmd_o          : slave request (high while busy) and command.
//   s_addr_o/s_wdata_o       : captured address (select bits stripped), wdata.
//   s_ack_i/s_resp_i/s_rdata_i : slave completion, status, read data.
//   grant_id_o/busy_o        : current/last granted master, transaction in flight.
module xbar_slave_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned SLAVE_ID = 0,
    parameter int unsigned TIMEOUT  = 255,
    localparam int unsigned IdxW    = $clog2(N),
    localparam int unsigned AddrW   = 32 - IdxW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         m_req_i,
    input  logic [N-1:0]         m_cmd_i,
    input  logic [N-1:0][31:0]   m_addr_i,
    input  logic [N-1:0][31:0]   m_wdata_i,
    output logic [N-1:0]         m_ack_o,
    output logic                 m_resp_o,
    output logic [31:0]          m_rdata_o,
    output logic                 s_req_o,
    output logic                 s_cmd_o,
    output logic [AddrW-1:0]     s_addr_o,
    output logic [31:0]          s_wdata_o,
    input  logic                 s_ack_i,
    input  logic                 s_resp_i,
    input  logic [31:0]          s_rdata_i,
    output logic [IdxW-1:0]      grant_id_o,
    output logic                 busy_o
);

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic              cmd_q, cmd_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [N-1:0]      eligible;
    logic              arb_valid;
    logic [IdxW-1:0]   arb_grant;

`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CntW-1:0]   cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eligible[i] = m_req_i[i] && (m_addr_i[i][31 -: IdxW] == IdxW'(SLAVE_ID));
        end
    end

    xbar_rr_arb #(
        .N (N)
    ) u_rr_arb (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .valid_o    (arb_valid),
        .grant_o    (arb_grant)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef XBAR_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        m_ack_o   = '0;
        m_resp_o  = RESP_OK;
        m_rdata_o = '0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StBusy;
                    grant_d = arb_grant;
                    ptr_d   = arb_grant + IdxW'(1);
                    cmd_d   = m_cmd_i[arb_grant];
                    addr_d  = m_addr_i[arb_grant][AddrW-1:0];
                    wdata_d = m_wdata_i[arb_grant];
`ifdef XBAR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StBusy: begin
                if (s_ack_i) begin
                    m_ack_o[grant_q] = 1'b1;
                    m_resp_o         = s_resp_i;
                    m_rdata_o        = s_rdata_i;
                    state_d          = StIdle;
`ifdef XBAR_ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    // A real slave ack in the same cycle takes precedence above.
                    m_ack_o[grant_q] = 1'b1;
                    m_resp_o         = RESP_ERR;
                    state_d          = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef XBAR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef XBAR_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy_o     = (state_q == StBusy);
    assign s_req_o    = busy_o;
    assign s_cmd_o    = cmd_q;
    assign s_addr_o   = addr_q;
    assign s_wdata_o  = wdata_q;
    assign grant_id_o = grant_q;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Bench for xbar_slave_arbiter: N=4, SLAVE_ID=1, TIMEOUT=8.
module tb_xbar_slave_arbiter;
    import xbar_pkg::*;

    localparam int unsigned NM  = 4;
    localparam logic [1:0]  SID = 2'd1;
`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int WrDelay = 6;
`else
    localparam int WrDelay = 10;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        m_req, m_cmd;
    logic [3:0][31:0]  m_addr, m_wdata;
    logic [3:0]        m_ack;
    logic              m_resp;
    logic [31:0]       m_rdata;
    logic              s_req, s_cmd;
    logic [29:0]       s_addr;
    logic [31:0]       s_wdata;
    logic              s_ack, s_resp;
    logic [31:0]       s_rdata;
    logic [1:0]        grant_id;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;
    int mptr    = 0;

    always #5 clk = ~clk;

    xbar_slave_arbiter #(
        .N        (NM),
        .SLAVE_ID (1),
        .TIMEOUT  (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m_req_i    (m_req),
        .m_cmd_i    (m_cmd),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_ack_o    (m_ack),
        .m_resp_o   (m_resp),
        .m_rdata_o  (m_rdata),
        .s_req_o    (s_req),
        .s_cmd_o    (s_cmd),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_ack_i    (s_ack),
        .s_resp_i   (s_resp),
        .s_rdata_i  (s_rdata),
        .grant_id_o (grant_id),
        .busy_o     (busy)
    );

    typedef struct packed {
        logic [3:0]      own;
        logic [3:0]      other;
        logic [2:0]      cnt;
        logic [3:0][1:0] order;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic cmd, input logic [1:0] sel,
                           input logic [29:0] low, input logic [31:0] wd);
        m_req[i]   = 1'b1;
        m_cmd[i]   = cmd;
        m_addr[i]  = {sel, low};
        m_wdata[i] = wd;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        m_req   = '0;
        m_cmd   = '0;
        m_addr  = '0;
        m_wdata = '0;
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_sreq", s_req, 0);
        check("rst_mack", m_ack, 0);
        check("rst_grant", grant_id, 0);
        check("rst_saddr", s_addr, 0);
        check("rst_swdata", s_wdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    // Grant of master g, slave answers after delay cycles, then completion.
    task automatic serve(input int g, input logic [31:0] rd, input logic rsp,
                         input int delay, input logic keep);
        logic [3:0] oh;
        logic [1:0] gi;
        gi = g[1:0];
        oh = '0;
        oh[g] = 1'b1;
        tick();
        check("grant_busy", busy, 1);
        check("grant_sreq", s_req, 1);
        check("grant_id", grant_id, gi);
        check("grant_saddr", s_addr, m_addr[g][29:0]);
        check("grant_scmd", s_cmd, m_cmd[g]);
        check("grant_swdata", s_wdata, m_wdata[g]);
        for (int d = 0; d < delay; d++) begin
            check("wait_mack", m_ack, 0);
            tick();
            check("hold_sreq", s_req, 1);
            check("hold_scmd", s_cmd, m_cmd[g]);
            check("hold_swdata", s_wdata, m_wdata[g]);
        end
        s_ack   = 1'b1;
        s_rdata = rd;
        s_resp  = rsp;
        #1;
        check("ack_mack", m_ack, oh);
        check("ack_rdata", m_rdata, rd);
        check("ack_resp", m_resp, rsp);
        tick();
        check("post_busy", busy, 0);
        check("post_mack", m_ack, 0);
        check("post_rdata", m_rdata, 0);
        check("post_resp", m_resp, 0);
        s_ack = 1'b0;
        if (!keep) m_req[g] = 1'b0;
    endtask

    // Reference pick: nearest requesting master addressed to this slave,
    // counting upward from the model pointer with wrap.
    function automatic int model_pick();
        for (int k = 0; k < NM; k++) begin
            int i;
            i = (mptr + k) % NM;
            if (m_req[i] && m_addr[i][31:30] == SID) return i;
        end
        return -1;
    endfunction

    initial begin
        vecs[0] = '{own: 4'b1011, other: 4'b0000, cnt: 3'd3, order: {2'd0, 2'd3, 2'd1, 2'd0}};
        vecs[1] = '{own: 4'b0100, other: 4'b0011, cnt: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[2] = '{own: 4'b0000, other: 4'b0010, cnt: 3'd0, order: '0};
        vecs[3] = '{own: 4'b1111, other: 4'b0000, cnt: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[4] = '{own: 4'b1000, other: 4'b0000, cnt: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[5] = '{own: 4'b0110, other: 4'b1001, cnt: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd1}};

        apply_reset();

        // Single read from master 2.
        set_req(2, CMD_READ, SID, 30'h0ABC_DEF0, 32'h0);
        serve(2, 32'hDEAD_BEEF, RESP_OK, 1, 1'b0);

        // Table: after reset, requesters served in the listed order.
        for (int v = 0; v < 6; v++) begin
            apply_reset();
            for (int i = 0; i < NM; i++) begin
                if (vecs[v].own[i])
                    set_req(i, i[0], SID, 30'(32'h100 * (i + 1) + v), 32'h5500_0000 + i);
                else if (vecs[v].other[i])
                    set_req(i, CMD_READ, 2'd3 - 2'(i), 30'h77, 32'h0);
            end
            if (vecs[v].cnt == 0) begin
                s_ack = 1'b1;
                s_rdata = 32'hFFFF_FFFF;
                for (int c = 0; c < 4; c++) begin
                    tick();
                    check("filt_sreq", s_req, 0);
                    check("filt_mack", m_ack, 0);
                end
                s_ack = 1'b0;
            end
            for (int j = 0; j < int'(vecs[v].cnt); j++)
                serve(int'(vecs[v].order[j]), 32'hA000_0000 + j, RESP_OK, j, 1'b0);
            m_req = '0;
        end

        // Master 0 keeps requesting after its ack and is served after 3.
        apply_reset();
        set_req(0, CMD_READ, SID, 30'h10, 32'h0);
        set_req(1, CMD_WRITE, SID, 30'h20, 32'h1111);
        set_req(3, CMD_READ, SID, 30'h30, 32'h0);
        serve(0, 32'h1, RESP_OK, 0, 1'b1);
        serve(1, 32'h2, RESP_OK, 0, 1'b0);
        serve(3, 32'h3, RESP_ERR, 0, 1'b0);
        serve(0, 32'h4, RESP_OK, 0, 1'b0);

        // Write with a slow slave: command and data held the whole time.
        apply_reset();
        set_req(3, CMD_WRITE, SID, 30'h3FFF_FFFC, 32'h1234_5678);
        serve(3, 32'h0, RESP_OK, WrDelay, 1'b0);
        tick();
        check("wr_single_ack", m_ack, 0);

        // Reset in the middle of a transaction.
        apply_reset();
        set_req(2, CMD_READ, SID, 30'h222, 32'h0);
        set_req(3, CMD_READ, SID, 30'h333, 32'h0);
        tick();
        check("mid_grant", grant_id, 2);
        tick();
        rst_n = 1'b0;
        s_ack = 1'b1;
        #1;
        check("mid_rst_sreq", s_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mack", m_ack, 0);
        tick();
        check("mid_rst_mack2", m_ack, 0);
        tick();
        check("mid_rst_mack3", m_ack, 0);
        s_ack    = 1'b0;
        m_req[2] = 1'b0;
        set_req(1, CMD_WRITE, SID, 30'h111, 32'hCAFE);
        rst_n = 1'b1;
        serve(1, 32'h9, RESP_OK, 0, 1'b0);

`ifdef XBAR_ARB_TIMEOUT_EN
        // Slave never answers: error completion after 8 busy cycles.
        apply_reset();
        s_rdata = 32'hFFFF_FFFF;
        set_req(0, CMD_READ, SID, 30'h44, 32'h0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("to_wait_mack", m_ack, 0);
            tick();
        end
        check("to_mack", m_ack, 4'b0001);
        check("to_resp", m_resp, 1);
        check("to_rdata", m_rdata, 0);
        tick();
        m_req[0] = 1'b0;
        check("to_sreq_low", s_req, 0);
`endif

        // Randomized traffic against the reference pick.
        apply_reset();
        for (int it = 0; it < 300; it++) begin
            int g;
            for (int i = 0; i < NM; i++) begin
                if (m_req[i] && m_addr[i][31:30] != SID && ($urandom % 2 == 0)) begin
                    m_req[i] = 1'b0;
                end else if (!m_req[i] && ($urandom % 2 == 0)) begin
                    logic [1:0] sel;
                    sel = ($urandom % 3 == 0) ? 2'($urandom) : SID;
                    set_req(i, 1'($urandom), sel, 30'($urandom), $urandom);
                end
            end
            g = model_pick();
            if (g < 0) begin
                s_ack = 1'($urandom);
                tick();
                check("rnd_idle_busy", busy, 0);
                check("rnd_idle_mack", m_ack, 0);
                s_ack = 1'b0;
            end else begin
                serve(g, $urandom, 1'($urandom), int'($urandom % 4), ($urandom % 4 == 0));
                mptr = (g + 1) % NM;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
